ncl_ring_model: RTL and testbench

- Clocked, cycle-accurate emulation of a parametrised N-stage, WIDTH-bit dual-rail NCL ring. Each stage is a TH22 register gated by downstream completion.
- Per-stage forward padding delay and a global completion-path delay reproduce the ring-ratio behaviour of the unclocked gate-level rings on a synchronous fabric.
- Built-in instrumentation: a wavefront counter, a period meter and a deadlock watchdog.
- Sits alongside the gate-level ring testbenches as a fast reference model and FPGA demonstrator.

---
 rtl/ncl_ring_pkg.sv | 48 ++++
 rtl/ncl_ring_stage.sv | 110 +++++++++++
 rtl/ncl_ring_model.sv | 146 ++++++++++++++
 tb/tb_ncl_ring_model.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/ncl_ring_pkg.sv
// rtl/ncl_ring_pkg.sv - rail encodings and C-element helpers for the NCL ring model
//
// Purpose : shared dual-rail encodings and per-bit next-state rules used by
//           ncl_ring_stage and ncl_ring_model.
// Ports   : none (package).

package ncl_ring_pkg;

    typedef logic [1:0] rail_t;

    // {rail1, rail0}; 2'b11 is illegal and never produced by the rule set.
    localparam rail_t RAIL_NULL = 2'b00;
    localparam rail_t RAIL_D0   = 2'b01;
    localparam rail_t RAIL_D1   = 2'b10;

    // Exactly one rail high means a valid DATA symbol.
    function automatic logic is_data(input rail_t r);
        return r[1] ^ r[0];
    endfunction

    // TH22 behaviour of one dual-rail bit: pass DATA when enabled, pass NULL
    // when disabled, otherwise hold.
    function automatic rail_t c_next(input rail_t cur, input rail_t in, input logic en);
        rail_t nxt;
        if (is_data(in) && en) begin
            nxt = in;
        end else if ((in == RAIL_NULL) && !en) begin
            nxt = RAIL_NULL;
        end else begin
            nxt = cur;
        end
        return nxt;
    endfunction

    // Reset-time rail value of one bit.
    function automatic rail_t init_rail(input logic data, input logic val);
        rail_t r;
        if (!data) begin
            r = RAIL_NULL;
        end else if (val) begin
            r = RAIL_D1;
        end else begin
            r = RAIL_D0;
        end
        return r;
    endfunction

endpackage

// File: rtl/ncl_ring_stage.sv
// rtl/ncl_ring_stage.sv - one WIDTH-bit dual-rail ring stage with padding and completion pipe
//
// Purpose : C-element register, forward-padding counter, completion detect and
//           completion delay pipe of a single ring stage.
// Ports   : i_clk, i_rst (async active-high), i_run (advance enable),
//           i_in (upstream rails), i_en (downstream not complete),
//           o_state (stage rails), o_comp_d (delayed completion),
//           o_update (stage rails change on this edge).

module ncl_ring_stage
    import ncl_ring_pkg::*;
#(
    parameter int              WIDTH     = 1,
    parameter int              DW        = 4,
    parameter logic [DW-1:0]   DLY       = '0,
    parameter int              CMP_DLY   = 2,
    parameter logic            INIT_DATA = 1'b0,
    parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_run,
    input  logic [2*WIDTH-1:0] i_in,
    input  logic               i_en,
    output logic [2*WIDTH-1:0] o_state,
    output logic               o_comp_d,
    output logic               o_update
);

    logic [2*WIDTH-1:0] r_state;
    logic [2*WIDTH-1:0] w_next;
    logic [DW-1:0]      r_cnt;
    logic               r_comp_prev;
    logic               w_comp;
    logic               w_all_data;
    logic               w_all_null;
    logic               w_pending;
    logic               w_fire;
    logic               w_illegal;

    always_comb begin
        w_next     = '0;
        w_all_data = 1'b1;
        w_all_null = 1'b1;
        w_illegal  = 1'b0;
        for (int b = 0; b < WIDTH; b++) begin
            w_next[2*b +: 2] = c_next(r_state[2*b +: 2], i_in[2*b +: 2], i_en);
            if (!is_data(r_state[2*b +: 2])) begin
                w_all_data = 1'b0;
            end
            if (r_state[2*b +: 2] != RAIL_NULL) begin
                w_all_null = 1'b0;
            end
            if (r_state[2*b +: 2] == 2'b11) begin
                w_illegal = 1'b1;
            end
        end
    end

    // A partially switched word keeps reporting the completion it had before.
    assign w_comp    = w_all_data | (~w_all_null & r_comp_prev);
    assign w_pending = (w_next != r_state);
    // All bits commit together once the change has been pending DLY+1 edges.
    assign w_fire    = w_pending && (r_cnt == DLY);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int b = 0; b < WIDTH; b++) begin
                r_state[2*b +: 2] <= init_rail(INIT_DATA, INIT_VAL[b]);
            end
            r_cnt       <= '0;
            r_comp_prev <= INIT_DATA;
        end else if (i_run) begin
            if (w_fire) begin
                r_state <= w_next;
            end
            if (w_fire || !w_pending) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            r_comp_prev <= w_comp;
        end
    end

    generate
        if (CMP_DLY == 0) begin : g_cmp_comb
            assign o_comp_d = w_comp;
        end else begin : g_cmp_pipe
            logic [CMP_DLY-1:0] r_pipe;
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    r_pipe <= {CMP_DLY{INIT_DATA}};
                end else if (i_run) begin
                    r_pipe[0] <= w_comp;
                    for (int k = 1; k < CMP_DLY; k++) begin
                        r_pipe[k] <= r_pipe[k-1];
                    end
                end
            end
            assign o_comp_d = r_pipe[CMP_DLY-1];
        end
    endgenerate

    assign o_state  = r_state;
    assign o_update = i_run & w_fire;

    a_no_illegal_rails: assert property (@(posedge i_clk) disable iff (i_rst) !w_illegal);

endmodule

// File: rtl/ncl_ring_model.sv
// rtl/ncl_ring_model.sv - clocked N-stage dual-rail NCL ring with wavefront, period and deadlock monitors
//
// Purpose : ring wiring of N ncl_ring_stage instances plus stage-0 arrival
//           monitor (wavefront count, period meter) and stall watchdog.
// Ports   : i_clk, i_init (async active-high reset), i_run (advance enable),
//           o_ring_state (rails of all stages, stage i at [2*WIDTH*i +: 2*WIDTH]),
//           o_comp_vec (delayed completion per stage), o_wave_cnt, o_period,
//           o_period_valid, o_deadlock (sticky).

module ncl_ring_model
    import ncl_ring_pkg::*;
#(
    parameter int                 N         = 24,
    parameter int                 WIDTH     = 1,
    parameter int                 DW        = 4,
    parameter logic [N*DW-1:0]    FWD_DLY   = '0,
    parameter int                 CMP_DLY   = 2,
    parameter logic [N-1:0]       INIT_DATA = {{(N-1){1'b0}}, 1'b1},
    parameter logic [N*WIDTH-1:0] INIT_VAL  = '0,
    parameter int                 CW        = 16,
    parameter int                 STALL_LIM = 64
) (
    input  logic                 i_clk,
    input  logic                 i_init,
    input  logic                 i_run,
    output logic [2*WIDTH*N-1:0] o_ring_state,
    output logic [N-1:0]         o_comp_vec,
    output logic [CW-1:0]        o_wave_cnt,
    output logic [CW-1:0]        o_period,
    output logic                 o_period_valid,
    output logic                 o_deadlock
);

    localparam int            SW          = 2 * WIDTH;
    localparam logic [CW-1:0] STALL_LIM_C = CW'(STALL_LIM);

    logic [SW*N-1:0] w_ring;
    logic [N-1:0]    w_comp_d;
    logic [N-1:0]    w_upd;

    generate
        for (genvar i = 0; i < N; i++) begin : g_stage
            localparam int IP = (i + N - 1) % N;
            localparam int IN = (i + 1) % N;
            ncl_ring_stage #(
                .WIDTH     (WIDTH),
                .DW        (DW),
                .DLY       (FWD_DLY[i*DW +: DW]),
                .CMP_DLY   (CMP_DLY),
                .INIT_DATA (INIT_DATA[i]),
                .INIT_VAL  (INIT_VAL[i*WIDTH +: WIDTH])
            ) u_stage (
                .i_clk    (i_clk),
                .i_rst    (i_init),
                .i_run    (i_run),
                .i_in     (w_ring[IP*SW +: SW]),
                .i_en     (~w_comp_d[IN]),
                .o_state  (w_ring[i*SW +: SW]),
                .o_comp_d (w_comp_d[i]),
                .o_update (w_upd[i])
            );
        end
    endgenerate

    // Stage-0 arrival: stage 0 is not fully DATA now and every bit is DATA
    // after this edge's update.
    logic w_s0_all_data;
    logic w_s0_next_all_data;
    logic w_arrive;

    always_comb begin
        w_s0_all_data      = 1'b1;
        w_s0_next_all_data = 1'b1;
        for (int b = 0; b < WIDTH; b++) begin
            if (!is_data(w_ring[2*b +: 2])) begin
                w_s0_all_data = 1'b0;
            end
            if (!is_data(c_next(w_ring[2*b +: 2], w_ring[(N-1)*SW + 2*b +: 2], ~w_comp_d[1 % N]))) begin
                w_s0_next_all_data = 1'b0;
            end
        end
    end

    assign w_arrive = w_upd[0] & ~w_s0_all_data & w_s0_next_all_data;

    logic [CW-1:0] r_wave_cnt;
    logic [CW-1:0] r_period;
    logic [CW-1:0] r_cyc;
    logic          r_seen;
    logic          r_period_valid;

    always_ff @(posedge i_clk or posedge i_init) begin
        if (i_init) begin
            r_wave_cnt     <= '0;
            r_period       <= '0;
            r_cyc          <= '0;
            r_seen         <= 1'b0;
            r_period_valid <= 1'b0;
        end else if (i_run) begin
            if (w_arrive) begin
                r_wave_cnt <= r_wave_cnt + 1'b1;
                r_period   <= r_cyc;
                r_cyc      <= CW'(1);
                r_seen     <= 1'b1;
                if (r_seen) begin
                    r_period_valid <= 1'b1;
                end
            end else if (r_cyc != '1) begin
                r_cyc <= r_cyc + 1'b1;
            end
        end
    end

    logic [CW-1:0] r_stall;
    logic [CW-1:0] w_stall_next;
    logic          r_deadlock;

    always_comb begin
        w_stall_next = r_stall;
        if (|w_upd) begin
            w_stall_next = '0;
        end else if (r_stall != '1) begin
            w_stall_next = r_stall + 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_init) begin
        if (i_init) begin
            r_stall    <= '0;
            r_deadlock <= 1'b0;
        end else if (i_run) begin
            r_stall <= w_stall_next;
            if (w_stall_next >= STALL_LIM_C) begin
                r_deadlock <= 1'b1;
            end
        end
    end

    assign o_ring_state   = w_ring;
    assign o_comp_vec     = w_comp_d;
    assign o_wave_cnt     = r_wave_cnt;
    assign o_period       = r_period;
    assign o_period_valid = r_period_valid;
    assign o_deadlock     = r_deadlock;

endmodule

// File: tb/tb_ncl_ring_model.sv
// tb/tb_ncl_ring_model.sv - directed self-checking bench for ncl_ring_model

module tb_ncl_ring_model;

    logic clk  = 1'b0;
    logic init = 1'b1;
    logic run  = 1'b1;

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // A: basic 4-stage ring; B: DATA1 token; C: one cycle padding per stage;
    // D: 2-stage deadlock; E: all-NULL deadlock.
    logic [7:0]  a_ring, b_ring, c_ring, e_ring;
    logic [3:0]  a_comp, b_comp, c_comp, e_comp;
    logic [15:0] a_wave, b_wave, c_wave, e_wave;
    logic [15:0] a_per, b_per, c_per, e_per;
    logic        a_pv, b_pv, c_pv, e_pv;
    logic        a_dl, b_dl, c_dl, e_dl;
    logic [3:0]  d_ring;
    logic [1:0]  d_comp;
    logic [15:0] d_wave, d_per;
    logic        d_pv, d_dl;

    ncl_ring_model #(.N(4), .CMP_DLY(0), .INIT_DATA(4'b0001)) u_a (
        .i_clk(clk), .i_init(init), .i_run(run), .o_ring_state(a_ring), .o_comp_vec(a_comp),
        .o_wave_cnt(a_wave), .o_period(a_per), .o_period_valid(a_pv), .o_deadlock(a_dl));

    ncl_ring_model #(.N(4), .CMP_DLY(0), .INIT_DATA(4'b0001), .INIT_VAL(4'b0001)) u_b (
        .i_clk(clk), .i_init(init), .i_run(run), .o_ring_state(b_ring), .o_comp_vec(b_comp),
        .o_wave_cnt(b_wave), .o_period(b_per), .o_period_valid(b_pv), .o_deadlock(b_dl));

    ncl_ring_model #(.N(4), .CMP_DLY(0), .INIT_DATA(4'b0001), .FWD_DLY(16'h1111)) u_c (
        .i_clk(clk), .i_init(init), .i_run(run), .o_ring_state(c_ring), .o_comp_vec(c_comp),
        .o_wave_cnt(c_wave), .o_period(c_per), .o_period_valid(c_pv), .o_deadlock(c_dl));

    ncl_ring_model #(.N(2), .CMP_DLY(0), .INIT_DATA(2'b01), .STALL_LIM(16)) u_d (
        .i_clk(clk), .i_init(init), .i_run(run), .o_ring_state(d_ring), .o_comp_vec(d_comp),
        .o_wave_cnt(d_wave), .o_period(d_per), .o_period_valid(d_pv), .o_deadlock(d_dl));

    ncl_ring_model #(.N(4), .CMP_DLY(0), .INIT_DATA(4'b0000), .STALL_LIM(16)) u_e (
        .i_clk(clk), .i_init(init), .i_run(run), .o_ring_state(e_ring), .o_comp_vec(e_comp),
        .o_wave_cnt(e_wave), .o_period(e_per), .o_period_valid(e_pv), .o_deadlock(e_dl));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hand-derived 4-stage sequence: edge0 D,N,N,N; 1 D,D,N,N; 2 N,D,D,N;
    // 3 N,N,D,D; 4 D,N,N,D; then period 4. d = rails of the token.
    function automatic logic [7:0] ring_pat(input int k, input logic [1:0] d);
        logic [7:0] r;
        if (k == 0) begin
            r = {6'b0, d};
        end else begin
            case (k % 4)
                1:       r = {4'b0, d, d};
                2:       r = {2'b0, d, d, 2'b0};
                3:       r = {d, d, 4'b0};
                default: r = {d, 4'b0, d};
            endcase
        end
        return r;
    endfunction

    function automatic logic [3:0] comp_pat(input int k);
        logic [3:0] r;
        if (k == 0) begin
            r = 4'b0001;
        end else begin
            case (k % 4)
                1:       r = 4'b0011;
                2:       r = 4'b0110;
                3:       r = 4'b1100;
                default: r = 4'b1001;
            endcase
        end
        return r;
    endfunction

    initial begin
        #18;
        check("rst_a_ring", a_ring, 8'h01);
        check("rst_a_comp", a_comp, 4'b0001);
        check("rst_a_wave", a_wave, 0);
        check("rst_a_period", a_per, 0);
        check("rst_a_pvalid", a_pv, 0);
        check("rst_a_deadlock", a_dl, 0);
        check("rst_b_ring", b_ring, 8'h02);
        check("rst_d_deadlock", d_dl, 0);
        #4 init = 1'b0;

        for (int k = 1; k <= 24; k++) begin
            step();
            check($sformatf("a_ring@%0d", k), a_ring, ring_pat(k, 2'b01));
            check($sformatf("a_comp@%0d", k), a_comp, comp_pat(k));
            check($sformatf("b_ring@%0d", k), b_ring, ring_pat(k, 2'b10));
            check($sformatf("c_ring@%0d", k), c_ring, ring_pat(k / 2, 2'b01));
            if (k == 4) check("a_wave@4", a_wave, 1);
            if (k == 7) check("a_pvalid@7", a_pv, 0);
            if (k == 8) begin
                check("a_wave@8", a_wave, 2);
                check("a_period@8", a_per, 4);
                check("a_pvalid@8", a_pv, 1);
            end
            if (k == 12) begin
                check("a_wave@12", a_wave, 3);
                check("a_period@12", a_per, 4);
                check("a_pvalid@12", a_pv, 1);
            end
            if (k == 15) begin
                check("d_deadlock@15", d_dl, 0);
                check("e_deadlock@15", e_dl, 0);
            end
            if (k == 16) begin
                check("d_deadlock@16", d_dl, 1);
                check("d_wave@16", d_wave, 0);
                check("d_ring@16", d_ring, 4'h1);
                check("e_deadlock@16", e_dl, 1);
                check("e_pvalid@16", e_pv, 0);
                check("e_ring@16", e_ring, 8'h00);
                check("c_wave@16", c_wave, 2);
                check("c_period@16", c_per, 8);
                check("c_pvalid@16", c_pv, 1);
            end
            if (k == 24) begin
                check("c_wave@24", c_wave, 3);
                check("c_period@24", c_per, 8);
                check("a_wave@24", a_wave, 6);
                check("a_deadlock@24", a_dl, 0);
            end
        end

        run = 1'b0;
        repeat (10) step();
        check("frz_a_ring", a_ring, 8'h41);
        check("frz_a_comp", a_comp, 4'b1001);
        check("frz_a_wave", a_wave, 6);
        check("frz_a_period", a_per, 4);
        check("frz_c_ring", c_ring, 8'h41);
        check("frz_c_wave", c_wave, 3);
        check("frz_d_deadlock", d_dl, 1);

        run = 1'b1;
        step();
        check("resume_a_ring@25", a_ring, 8'h05);
        step();
        step();
        check("resume_a_ring@27", a_ring, 8'h50);
        step();
        check("resume_a_ring@28", a_ring, 8'h41);
        check("resume_a_wave@28", a_wave, 7);
        check("resume_a_period@28", a_per, 4);

        step();
        check("pre_init_a_ring", a_ring, 8'h05);
        #3 init = 1'b1;
        #1;
        check("init_a_ring", a_ring, 8'h01);
        check("init_a_comp", a_comp, 4'b0001);
        check("init_a_wave", a_wave, 0);
        check("init_a_period", a_per, 0);
        check("init_a_pvalid", a_pv, 0);
        check("init_c_ring", c_ring, 8'h01);
        check("init_d_deadlock", d_dl, 0);
        #2 init = 1'b0;
        step();
        check("restart_a_ring@1", a_ring, 8'h05);
        check("restart_a_wave@1", a_wave, 0);
        repeat (3) step();
        check("restart_a_ring@4", a_ring, 8'h41);
        check("restart_a_wave@4", a_wave, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
